// File: rtl/xfer_slot_pkg.sv
// Shared types and constants for the transfer slot scheduler.
package xfer_slot_pkg;
  localparam int DW_DEF   = 12;
  localparam int NCH_MAX  = 8;
  localparam int STALL_W  = 16;
  localparam int CH_IDX_W = $clog2(NCH_MAX);

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // Saturating increment for the per-channel stall counters.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/xfer_slot_scheduler_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] win_oh,
  output logic [IW-1:0]  win_idx,
  output logic           any
);
  int j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(ptr) + i;
      if (j >= NCH) j = j - NCH;
      if (!any && req[j]) begin
        any        = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/xfer_slot_scheduler.sv
// Round-robin slot scheduler feeding the shared fast-domain holding register.
// Optional per-channel stall statistics enabled by defining XFER_SLOT_STATS_EN.
module xfer_slot_scheduler
  import xfer_slot_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = DW_DEF,
  parameter int DIV_W = 8,
  parameter int IW    = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] data,
  output logic [NCH-1:0]    grant,
  output logic              hold_en,
  output logic [DW-1:0]     hold_data,
  output logic [IW-1:0]     hold_ch,
  output logic              slot_tick
`ifdef XFER_SLOT_STATS_EN
  ,
  output logic [NCH*STALL_W-1:0] stall_cnt
`endif
);
  logic [DIV_W-1:0]          cnt;
  logic [IW-1:0]             rr_ptr;
  logic [NCH-1:0]            win_oh;
  logic [IW-1:0]             win_idx;
  logic                      any;
  logic                      load;
  logic [NCH-1:0][DW-1:0]    data_v;

  assign data_v = data;

  // >= compare lets a shrinking div wrap immediately instead of overrunning.
  assign slot_tick = ~reset & (cnt >= div);
  assign load      = slot_tick & any;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      hold_en   <= 1'b0;
      hold_data <= '0;
      hold_ch   <= '0;
    end else begin
      cnt     <= slot_tick ? '0 : cnt + 1'b1;
      grant   <= load ? win_oh : '0;
      hold_en <= load;
      if (load) begin
        hold_data <= data_v[win_idx];
        hold_ch   <= win_idx;
        rr_ptr    <= (int'(win_idx) == NCH-1) ? '0 : win_idx + 1'b1;
      end
    end
  end

`ifdef XFER_SLOT_STATS_EN
  logic [NCH-1:0][STALL_W-1:0] stall_q;

  // A stall is a tick where the channel asked but someone else won.
  for (genvar g = 0; g < NCH; g++) begin : g_stall
    always_ff @(posedge clk) begin
      if (reset)
        stall_q[g] <= '0;
      else if (slot_tick && req[g] && !win_oh[g])
        stall_q[g] <= sat_inc(stall_q[g]);
    end
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_xfer_slot_scheduler.sv
// Scoreboard bench for xfer_slot_scheduler: expectations queued at each tick, compared one cycle later.
module tb_xfer_slot_scheduler;
  localparam int NCH   = 4;
  localparam int DW    = 12;
  localparam int DIV_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIV_W-1:0]  div;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0]    grant;
  logic              hold_en;
  logic [DW-1:0]     hold_data;
  logic [1:0]        hold_ch;
  logic              slot_tick;
`ifdef XFER_SLOT_STATS_EN
  logic [NCH*16-1:0] stall_cnt;
`endif

  xfer_slot_scheduler #(.NCH(NCH), .DW(DW), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .hold_en   (hold_en),
    .hold_data (hold_data),
    .hold_ch   (hold_ch),
    .slot_tick (slot_tick)
`ifdef XFER_SLOT_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] g;
    logic [DW-1:0]  d;
    logic [1:0]     c;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          m_cnt  = 0;
  int          m_ptr  = 0;
  logic [DW-1:0] m_hd = '0;
  logic [1:0]  m_hc   = '0;
  int          m_stall[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: compare outputs, advance the model, step past the clock edge.
  task automatic cyc();
    exp_t           e;
    logic [NCH-1:0] eg;
    logic           eh;
    int             w;
    int             c;
    #1;
    check("slot_tick", slot_tick, (!reset && m_cnt >= int'(div)));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      eh = 1'b1; eg = e.g; m_hd = e.d; m_hc = e.c;
    end else begin
      eh = 1'b0; eg = '0;
    end
    check("hold_en", hold_en, eh);
    check("grant", grant, eg);
    check("hold_data", hold_data, m_hd);
    check("hold_ch", hold_ch, m_hc);
`ifdef XFER_SLOT_STATS_EN
    for (int i = 0; i < NCH; i++)
      check($sformatf("stall_cnt%0d", i), stall_cnt[i*16 +: 16], m_stall[i]);
`endif
    if (reset) begin
      m_cnt = 0; m_ptr = 0; m_hd = '0; m_hc = '0;
      sb.delete();
      for (int i = 0; i < NCH; i++) m_stall[i] = 0;
    end else if (m_cnt >= int'(div)) begin
      w = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (w < 0 && req[c]) w = c;
      end
      if (w >= 0) begin
        e.g = '0; e.g[w] = 1'b1;
        e.d = data[w*DW +: DW];
        e.c = w[1:0];
        sb.push_back(e);
        m_ptr = (w + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++)
        if (req[i] && i != w && m_stall[i] < 16'hFFFF) m_stall[i]++;
      m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int n;
    for (int i = 0; i < NCH; i++) m_stall[i] = 0;
    reset = 1'b1; div = 8'd3; req = '0; data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc();

    // Single requester, slot every 4 cycles
    reset = 1'b0;
    req = 4'b0001;
    data[0 +: DW] = 12'hABC;
    run(13);

    // Idle tick keeps previous sample and pointer
    data[0 +: DW] = 12'h5A5;
    run(4);
    req = 4'b0000;
    run(9);
    #1;
    check("idle_hold_data", hold_data, 12'h5A5);
    check("idle_hold_ch", hold_ch, 0);

    // All requesting, div=1, data changing every cycle
    req = 4'b1111; div = 8'd1;
    for (int i = 0; i < 20; i++) begin
      data = {$urandom, $urandom};
      cyc();
    end

    // div lowered mid-count
    req = 4'b0001; div = 8'd200;
    n = 0;
    while (m_cnt != 50 && n < 400) begin
      cyc();
      n++;
    end
    check("reach_cnt50", (m_cnt == 50), 1);
    div = 8'd2;
    #1;
    check("div_shrink_tick", slot_tick, 1);
    run(10);

    // Slot every cycle
    div = 8'd0; req = 4'b0100;
    data[2*DW +: DW] = 12'h123;
    run(6);
    #1;
    check("div0_hold_en", hold_en, 1);
    check("div0_grant", grant, 4'b0100);

    // Reset in a tick cycle discards the pending load
    req = 4'b0010;
    data[1*DW +: DW] = 12'h777;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rst_hold_en", hold_en, 0);
    check("rst_grant", grant, 0);
    check("rst_hold_data", hold_data, 0);
    run(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
